// File: rtl/jtag_user_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_user_pkg : shared types and constants for jtag_user_dr      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package jtag_user_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_SHIFTING = 1'b1
  } state_t;

  localparam logic [7:0] IR_ER1 = 8'h32;
  localparam logic [7:0] IR_ER2 = 8'h38;

  localparam int CHAIN_ER1 = 0;
  localparam int CHAIN_ER2 = 1;

  function automatic logic [7:0] chain_ir(input int chain);
    return (chain == CHAIN_ER2) ? IR_ER2 : IR_ER1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_user_dr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtag_user_dr : JTAGG ER1/ER2 user data registers, LSB-first      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module jtag_user_dr
  import jtag_user_pkg::*;
#(
  parameter int NUM_CHAINS = 2,
  parameter int DR_WIDTH   = 32
) (
  input  logic                           JTCK,
  input  logic                           rst,
  input  logic [NUM_CHAINS-1:0]          JCE,
  input  logic                           JSHIFT,
  input  logic                           JUPDATE,
  input  logic                           JRSTN,
  input  logic                           JTDI,
  input  logic [NUM_CHAINS*DR_WIDTH-1:0] capture_data_i,
  output logic [NUM_CHAINS-1:0]          JTDO,
  output logic [DR_WIDTH-1:0]            update_data_o,
  output logic [NUM_CHAINS-1:0]          update_valid_o,
  output logic                           len_err_o,
  output logic [NUM_CHAINS-1:0]          chain_sel_o,
  output logic                           tap_rst_o
);

  localparam int AW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int CW = $clog2(DR_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DR_WIDTH + 1);

  state_t                  state, state_nxt;
  logic [DR_WIDTH-1:0]     sr, sr_nxt;
  logic [CW-1:0]           count, count_nxt;
  logic [AW-1:0]           active, active_nxt;
  logic [DR_WIDTH-1:0]     update_data_nxt;
  logic [NUM_CHAINS-1:0]   update_valid_nxt;
  logic                    len_err_nxt;
  logic [NUM_CHAINS-1:0]   chain_sel_nxt;
  logic                    cap_hit;
  logic [AW-1:0]           cap_idx;
  logic [DR_WIDTH-1:0]     cap_slice;

  // Descending scan so the lowest qualifying chain is the one left standing.
  always_comb begin
    cap_hit = 1'b0;
    cap_idx = '0;
    for (int c = NUM_CHAINS - 1; c >= 0; c--) begin
      if (JCE[c] && !JSHIFT) begin
        cap_hit = 1'b1;
        cap_idx = AW'(c);
      end
    end
  end

  assign cap_slice = capture_data_i[cap_idx*DR_WIDTH +: DR_WIDTH];

  always_comb begin
    state_nxt        = state;
    sr_nxt           = sr;
    count_nxt        = count;
    active_nxt       = active;
    update_data_nxt  = update_data_o;
    update_valid_nxt = '0;
    len_err_nxt      = 1'b0;
    chain_sel_nxt    = chain_sel_o;
    if (!JRSTN) begin
      state_nxt     = ST_IDLE;
      count_nxt     = '0;
      chain_sel_nxt = '0;
    end else if (cap_hit) begin
      state_nxt              = ST_SHIFTING;
      sr_nxt                 = cap_slice;
      active_nxt             = cap_idx;
      count_nxt              = '0;
      chain_sel_nxt[cap_idx] = 1'b1;
    end else if (state == ST_SHIFTING) begin
      if (JUPDATE) begin
        state_nxt = ST_IDLE;
        if (count == CNT_FULL) begin
          update_data_nxt          = sr;
          update_valid_nxt[active] = 1'b1;
        end else begin
          len_err_nxt = 1'b1;
        end
      end else if (JCE[active] && JSHIFT) begin
        sr_nxt = {JTDI, sr[DR_WIDTH-1:1]};
        // Saturate one past full so over-length shifts still flag an error.
        if (count != CNT_SAT) count_nxt = count + 1'b1;
      end
    end
  end

  always_ff @(posedge JTCK) begin
    if (rst) begin
      state          <= ST_IDLE;
      sr             <= '0;
      count          <= '0;
      active         <= '0;
      update_data_o  <= '0;
      update_valid_o <= '0;
      len_err_o      <= 1'b0;
      chain_sel_o    <= '0;
      tap_rst_o      <= 1'b1;
    end else begin
      state          <= state_nxt;
      sr             <= sr_nxt;
      count          <= count_nxt;
      active         <= active_nxt;
      update_data_o  <= update_data_nxt;
      update_valid_o <= update_valid_nxt;
      len_err_o      <= len_err_nxt;
      chain_sel_o    <= chain_sel_nxt;
      tap_rst_o      <= ~JRSTN;
    end
  end

  always_comb begin
    JTDO = '0;
    if (state == ST_SHIFTING) JTDO[active] = sr[0];
  end

endmodule
`default_nettype wire
